// File: rtl/width_conv_pkg.sv
// Shared definitions for the 16<->8 width converters (packer and serializer).
// State encoding and width constants live here so both directions stay aligned.
package width_conv_pkg;

    localparam int IN_W  = 16;
    localparam int OUT_W = 8;
    localparam int RATIO = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HI    = 2'd1,
        LO    = 2'd2
    } state_t;

endpackage

// File: rtl/width_16to8_if.sv
// Upstream word and downstream byte channels of the 16-to-8 serializer.
// Valid/ready: a transfer happens on a rising edge where both valid and ready are 1;
// once valid is raised, the sender holds valid and data stable until that transfer.
interface width_16to8_if;
    import width_conv_pkg::*;

    logic             valid_in;
    logic [IN_W-1:0]  data_in;
    logic             ready_in;
    logic             valid_out;
    logic [OUT_W-1:0] data_out;
    logic             last_out;
    logic             ready_out;

    modport slave (
        input  valid_in,
        input  data_in,
        input  ready_out,
        output ready_in,
        output valid_out,
        output data_out,
        output last_out
    );

    modport master (
        output valid_in,
        output data_in,
        output ready_out,
        input  ready_in,
        input  valid_out,
        input  data_out,
        input  last_out
    );

endinterface

// File: rtl/width_16to8.sv
// Serializes 16-bit words into two 8-bit bytes; all byte outputs are registered.
// A new word may be taken in the same cycle the second byte of the previous one leaves.
module width_16to8
    import width_conv_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    width_16to8_if.slave    bus,
    output state_t          fsm_state
);

    state_t           state, state_nxt;
    logic [OUT_W-1:0] data_q, data_nxt;
    logic [OUT_W-1:0] hold_q, hold_nxt;
    logic             valid_q, valid_nxt;
    logic             last_q, last_nxt;
    logic             ready;
    logic             acc;
    logic             tx;
    logic [OUT_W-1:0] first_byte;
    logic [OUT_W-1:0] second_byte;

    assign first_byte  = MSB_FIRST ? bus.data_in[IN_W-1 -: OUT_W] : bus.data_in[OUT_W-1:0];
    assign second_byte = MSB_FIRST ? bus.data_in[OUT_W-1:0] : bus.data_in[IN_W-1 -: OUT_W];

    // rst_n gating keeps ready low while reset is held even though state already reads EMPTY
    assign ready = rst_n & ((state == EMPTY) | ((state == LO) & bus.ready_out));
    assign acc   = bus.valid_in & ready;
    assign tx    = valid_q & bus.ready_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EMPTY;
            data_q  <= '0;
            hold_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            data_q  <= data_nxt;
            hold_q  <= hold_nxt;
            valid_q <= valid_nxt;
            last_q  <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        data_nxt  = data_q;
        hold_nxt  = hold_q;
        valid_nxt = valid_q;
        last_nxt  = last_q;
        case (state)
            EMPTY: begin
                valid_nxt = 1'b0;
                if (acc) begin
                    data_nxt  = first_byte;
                    hold_nxt  = second_byte;
                    valid_nxt = 1'b1;
                    last_nxt  = 1'b0;
                    state_nxt = HI;
                end
            end
            HI: begin
                if (tx) begin
                    data_nxt  = hold_q;
                    last_nxt  = 1'b1;
                    state_nxt = LO;
                end
            end
            LO: begin
                if (tx && acc) begin
                    data_nxt  = first_byte;
                    hold_nxt  = second_byte;
                    valid_nxt = 1'b1;
                    last_nxt  = 1'b0;
                    state_nxt = HI;
                end else if (tx) begin
                    valid_nxt = 1'b0;
                    last_nxt  = 1'b0;
                    state_nxt = EMPTY;
                end
            end
            default: begin
                valid_nxt = 1'b0;
                last_nxt  = 1'b0;
                state_nxt = EMPTY;
            end
        endcase
    end

    assign bus.ready_in  = ready;
    assign bus.valid_out = valid_q;
    assign bus.data_out  = data_q;
    assign bus.last_out  = last_q;
    assign fsm_state     = state;

endmodule

// File: tb/tb_width_16to8.sv
// Directed and scoreboard checks for the 16-to-8 serializer, both byte orders.
module tb_width_16to8;
    import width_conv_pkg::*;

    logic   clk;
    logic   rst_n;
    state_t state_m;
    state_t state_l;
    int     n_checks;
    int     n_fail;

    width_16to8_if bus_m ();
    width_16to8_if bus_l ();

    width_16to8 #(.MSB_FIRST(1'b1)) u_msb (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_m.slave),
        .fsm_state (state_m)
    );

    width_16to8 #(.MSB_FIRST(1'b0)) u_lsb (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_l.slave),
        .fsm_state (state_l)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_m.valid_in = 1'b0; bus_m.data_in = '0; bus_m.ready_out = 1'b0;
        bus_l.valid_in = 1'b0; bus_l.data_in = '0; bus_l.ready_out = 1'b0;
        tick(); tick();
        n_checks++;
        if (bus_m.valid_out !== 1'b0 || bus_m.data_out !== 8'h00 || bus_m.last_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b d=%h l=%b want v=0 d=00 l=0",
                     bus_m.valid_out, bus_m.data_out, bus_m.last_out);
        end
        n_checks++;
        if (bus_m.ready_in !== 1'b0 || bus_l.ready_in !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_low: got %b/%b want 0/0", bus_m.ready_in, bus_l.ready_in);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (bus_m.ready_in !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b want 1", bus_m.ready_in);
        end
        tick();
        // load a word, then reset while the first byte is pending
        bus_m.valid_in = 1'b1; bus_m.data_in = 16'hC3D4; bus_m.ready_out = 1'b0;
        tick();
        bus_m.valid_in = 1'b0;
        n_checks++;
        if (bus_m.valid_out !== 1'b1 || bus_m.data_out !== 8'hC3) begin
            n_fail++;
            $display("FAIL reset_preload: got v=%b d=%h want v=1 d=c3", bus_m.valid_out, bus_m.data_out);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus_m.valid_out !== 1'b0 || bus_m.data_out !== 8'h00 || bus_m.last_out !== 1'b0
            || bus_m.ready_in !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midword: got v=%b d=%h l=%b r=%b want v=0 d=00 l=0 r=0",
                     bus_m.valid_out, bus_m.data_out, bus_m.last_out, bus_m.ready_in);
        end
        #1 rst_n = 1'b1;
        #1;
        n_checks++;
        if (bus_m.ready_in !== 1'b1 || state_m !== EMPTY) begin
            n_fail++;
            $display("FAIL reset_restart: got r=%b s=%0d want r=1 s=0", bus_m.ready_in, state_m);
        end
        tick();
    endtask

    task automatic test_single_msb();
        bus_m.valid_in = 1'b1; bus_m.data_in = 16'hA55A; bus_m.ready_out = 1'b1;
        #1;
        n_checks++;
        if (bus_m.ready_in !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ready_empty: got %b want 1", bus_m.ready_in);
        end
        tick();
        bus_m.valid_in = 1'b0; bus_m.data_in = 'x;
        #1;
        n_checks++;
        if (bus_m.valid_out !== 1'b1 || bus_m.data_out !== 8'hA5 || bus_m.last_out !== 1'b0
            || bus_m.ready_in !== 1'b0) begin
            n_fail++;
            $display("FAIL single_byte0: got v=%b d=%h l=%b r=%b want v=1 d=a5 l=0 r=0",
                     bus_m.valid_out, bus_m.data_out, bus_m.last_out, bus_m.ready_in);
        end
        tick();
        n_checks++;
        if (bus_m.valid_out !== 1'b1 || bus_m.data_out !== 8'h5A || bus_m.last_out !== 1'b1
            || bus_m.ready_in !== 1'b1) begin
            n_fail++;
            $display("FAIL single_byte1: got v=%b d=%h l=%b r=%b want v=1 d=5a l=1 r=1",
                     bus_m.valid_out, bus_m.data_out, bus_m.last_out, bus_m.ready_in);
        end
        tick();
        n_checks++;
        if (bus_m.valid_out !== 1'b0 || bus_m.last_out !== 1'b0 || bus_m.data_out !== 8'h5A) begin
            n_fail++;
            $display("FAIL single_drain: got v=%b l=%b d=%h want v=0 l=0 d=5a",
                     bus_m.valid_out, bus_m.last_out, bus_m.data_out);
        end
        bus_m.data_in = '0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] words [3];
        words[0] = 16'h1234; words[1] = 16'h5678; words[2] = 16'h9ABC;
        bus_m.ready_out = 1'b1;
        for (int w = 0; w < 3; w++) begin
            bus_m.valid_in = 1'b1; bus_m.data_in = words[w];
            #1;
            n_checks++;
            if (bus_m.ready_in !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready_w%0d: got %b want 1", w, bus_m.ready_in);
            end
            tick();
            if (w == 2) bus_m.valid_in = 1'b0;
            #1;
            n_checks++;
            if (bus_m.valid_out !== 1'b1 || bus_m.data_out !== words[w][15:8] || bus_m.last_out !== 1'b0
                || bus_m.ready_in !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_hi_w%0d: got v=%b d=%h l=%b r=%b want v=1 d=%h l=0 r=0", w,
                         bus_m.valid_out, bus_m.data_out, bus_m.last_out, bus_m.ready_in, words[w][15:8]);
            end
            tick();
            n_checks++;
            if (bus_m.valid_out !== 1'b1 || bus_m.data_out !== words[w][7:0] || bus_m.last_out !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_lo_w%0d: got v=%b d=%h l=%b want v=1 d=%h l=1", w,
                         bus_m.valid_out, bus_m.data_out, bus_m.last_out, words[w][7:0]);
            end
        end
        tick();
        n_checks++;
        if (bus_m.valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain: got v=%b want 0", bus_m.valid_out);
        end
    endtask

    task automatic test_backpressure();
        bus_m.valid_in = 1'b1; bus_m.data_in = 16'h1234; bus_m.ready_out = 1'b0;
        tick();
        bus_m.valid_in = 1'b1; bus_m.data_in = 16'hFFFF;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (bus_m.valid_out !== 1'b1 || bus_m.data_out !== 8'h12 || bus_m.last_out !== 1'b0
                || bus_m.ready_in !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold_hi_c%0d: got v=%b d=%h l=%b r=%b want v=1 d=12 l=0 r=0", c,
                         bus_m.valid_out, bus_m.data_out, bus_m.last_out, bus_m.ready_in);
            end
            tick();
        end
        bus_m.valid_in = 1'b0;
        bus_m.ready_out = 1'b1;
        tick();
        bus_m.ready_out = 1'b0;
        bus_m.valid_in = 1'b1; bus_m.data_in = 16'h5678;
        #1;
        n_checks++;
        if (bus_m.data_out !== 8'h34 || bus_m.last_out !== 1'b1 || bus_m.ready_in !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_lo_stall: got d=%h l=%b r=%b want d=34 l=1 r=0",
                     bus_m.data_out, bus_m.last_out, bus_m.ready_in);
        end
        tick();
        n_checks++;
        if (bus_m.valid_out !== 1'b1 || bus_m.data_out !== 8'h34 || bus_m.last_out !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_lo_hold: got v=%b d=%h l=%b want v=1 d=34 l=1",
                     bus_m.valid_out, bus_m.data_out, bus_m.last_out);
        end
        bus_m.valid_in = 1'b0;
        bus_m.ready_out = 1'b1;
        tick();
        n_checks++;
        if (bus_m.valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: got v=%b want 0", bus_m.valid_out);
        end
    endtask

    task automatic test_lsb_first();
        bus_l.valid_in = 1'b1; bus_l.data_in = 16'hBEEF; bus_l.ready_out = 1'b1;
        tick();
        bus_l.valid_in = 1'b0;
        n_checks++;
        if (bus_l.valid_out !== 1'b1 || bus_l.data_out !== 8'hEF || bus_l.last_out !== 1'b0) begin
            n_fail++;
            $display("FAIL lsb_byte0: got v=%b d=%h l=%b want v=1 d=ef l=0",
                     bus_l.valid_out, bus_l.data_out, bus_l.last_out);
        end
        tick();
        n_checks++;
        if (bus_l.valid_out !== 1'b1 || bus_l.data_out !== 8'hBE || bus_l.last_out !== 1'b1) begin
            n_fail++;
            $display("FAIL lsb_byte1: got v=%b d=%h l=%b want v=1 d=be l=1",
                     bus_l.valid_out, bus_l.data_out, bus_l.last_out);
        end
        tick();
        n_checks++;
        if (bus_l.valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL lsb_drain: got v=%b want 0", bus_l.valid_out);
        end
    endtask

    // scoreboard: bytes pushed at input acceptance, popped at output transfer
    task automatic test_random_stream();
        logic [7:0] exp_q[$];
        int         n_words;
        int         words_in;
        int         bytes_out;
        logic       exp_last;
        logic       prev_valid;
        logic       prev_tx;
        logic [7:0] prev_data;
        logic       prev_last;
        logic       acc;
        logic       tx;
        logic [7:0] exp_b;
        n_words = 300; words_in = 0; bytes_out = 0; exp_last = 1'b0;
        prev_valid = 1'b0; prev_tx = 1'b0; prev_data = '0; prev_last = 1'b0;
        bus_m.valid_in = 1'b0; bus_m.ready_out = 1'b0;
        for (int cyc = 0; cyc < 20000 && bytes_out < 2 * n_words; cyc++) begin
            if (!bus_m.valid_in && words_in < n_words && $urandom_range(0, 3) != 0) begin
                bus_m.valid_in = 1'b1;
                bus_m.data_in  = 16'($urandom_range(0, 65535));
            end
            bus_m.ready_out = ($urandom_range(0, 3) != 0);
            #1;
            if (prev_valid && !prev_tx) begin
                n_checks++;
                if (bus_m.valid_out !== 1'b1 || bus_m.data_out !== prev_data || bus_m.last_out !== prev_last) begin
                    n_fail++;
                    $display("FAIL rand_stable: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             bus_m.valid_out, bus_m.data_out, bus_m.last_out, prev_data, prev_last);
                end
            end
            acc = bus_m.valid_in & bus_m.ready_in;
            tx  = bus_m.valid_out & bus_m.ready_out;
            if (tx) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_extra_byte: got d=%h want no byte", bus_m.data_out);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (bus_m.data_out !== exp_b || bus_m.last_out !== exp_last) begin
                        n_fail++;
                        $display("FAIL rand_byte%0d: got d=%h l=%b want d=%h l=%b", bytes_out,
                                 bus_m.data_out, bus_m.last_out, exp_b, exp_last);
                    end
                end
                exp_last = ~exp_last;
                bytes_out++;
            end
            if (acc) begin
                exp_q.push_back(bus_m.data_in[15:8]);
                exp_q.push_back(bus_m.data_in[7:0]);
                words_in++;
            end
            prev_valid = bus_m.valid_out;
            prev_tx    = tx;
            prev_data  = bus_m.data_out;
            prev_last  = bus_m.last_out;
            tick();
            if (acc) bus_m.valid_in = 1'b0;
        end
        n_checks++;
        if (bytes_out != 2 * n_words || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_complete: got %0d bytes (%0d queued) want %0d bytes (0 queued)",
                     bytes_out, exp_q.size(), 2 * n_words);
        end
        bus_m.valid_in = 1'b0;
        bus_m.ready_out = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single_msb();
        test_back_to_back();
        test_backpressure();
        test_lsb_first();
        test_random_stream();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
